fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the ARM-subset pipeline, directly upstream of decode (control unit + NOP-insertion mux). Owns the program counter, drives the combinational instruction ROM address, and registers the fetched word into the IF/ID pipeline register. Supports stalls, delayed-branch redirect from ID (including a redirect arriving during a stall), IF/ID flush to NOP, and a saturating fetch counter.

## Interface
Parameters:
- PC_W, 8, PC and ROM address width (byte address)
- INSTR_W, 32, instruction width
- CNT_W, 16, fetch counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset sampled on posedge clk only
- enable_pc  in  1  PC load enable; 0 = stall PC
- enable_ifid  in  1  IF/ID load enable; 0 = hold IF/ID
- flush_ifid  in  1  load NOP (all-zero word) into IF/ID
- branch_taken  in  1  branch resolved taken in ID
- branch_target  in  PC_W  branch destination
- rom_instr  in  INSTR_W  word from instruction ROM at rom_addr
- rom_addr  out  PC_W  ROM address, equals pc
- pc  out  PC_W  current PC
- ifid_instruction  out  INSTR_W  registered instruction to decode
- ifid_pc_plus4  out  PC_W  registered PC+4 of that instruction (BL link, target calc)
- ifid_valid  out  1  IF/ID holds a real fetched instruction
- redirect_pending  out  1  FSM in PENDING state
- fetch_count  out  CNT_W  instructions loaded into IF/ID since reset

## Operation
- FSM states: RUN, PENDING. Internal pending_target register (PC_W).
- Next-PC select, evaluated when enable_pc=1, priority: branch_taken → branch_target; else state PENDING → pending_target; else pc+4.
- PC+4 wraps modulo 2^PC_W (252 → 0 for PC_W=8).
- branch_taken=1 with enable_pc=0: pending_target ← branch_target, state → PENDING. Repeated assertion while stalled overwrites pending_target (newest wins).
- PENDING with enable_pc=1: PC loads (branch_target if branch_taken, else pending_target), state → RUN.
- RUN, branch_taken=1, enable_pc=1: PC ← branch_target, stays RUN.
- Delayed branch: instruction fetched in the cycle branch_taken is seen (delay slot) still enters IF/ID normally; the stage never auto-flushes.
- IF/ID update, priority: flush_ifid → instruction 0, pc_plus4 0, valid 0 (regardless of enable_ifid); else enable_ifid → rom_instr, pc+4, valid 1; else hold.
- fetch_count increments by 1 on every IF/ID load with valid 1; saturates at all-ones.
- reset overrides everything.

## Timing
- Reset values: pc 0, rom_addr 0, ifid_instruction 0, ifid_pc_plus4 0, ifid_valid 0, redirect_pending 0, fetch_count 0, state RUN, pending_target 0.
- rom_addr is combinational from pc; rom_instr assumed valid same cycle (combinational ROM).
- IF→IF/ID latency: 1 clock. Branch redirect: target appears on pc one posedge after branch_taken sampled with enable_pc=1.
- redirect_pending asserts the posedge after a stalled branch_taken; deasserts on the posedge PC loads the target.
- reset asserted in PENDING: pending target discarded, pc 0 next edge.
- enable_pc=0, enable_ifid=1: IF/ID reloads the same word every cycle; fetch_count counts each load (documented behaviour).

## Structure
- Shared package pipeline_pkg: PC_W, INSTR_W, PC_INC (4), NOP_INSTR (32'h0), fetch FSM state enum {RUN, PENDING}.
- One sub-module: if_id_register (instruction, pc_plus4, valid; enable + flush + synchronous reset). PC/next-PC logic, FSM and counter stay in fetch_stage.

## Test plan
- Reset held 2 cycles, release, enables=1, ROM words at 0,4,8 → pc 0,4,8,12 on successive edges; ifid_instruction = word@0 one cycle after release; ifid_pc_plus4 = 4; fetch_count 1,2,3.
- pc=8, branch_taken=1, target=40, enables=1 → next pc 40; IF/ID gets word@8 (delay slot), valid 1.
- enable_pc=0 at pc=16, branch_taken=1 target=60 for 1 cycle, stall 3 cycles → redirect_pending=1, pc stays 16; on release pc=60, redirect_pending=0.
- flush_ifid=1 with enable_ifid=0 → ifid_instruction 0, valid 0, fetch_count unchanged.
- Run from pc=248 → pc 252 then 0 (wrap).
- Reset asserted while PENDING (target 60) → next edge pc 0, redirect_pending 0, all outputs at reset values; no later jump to 60.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the ARM-subset pipeline: default widths, PC increment,
// the NOP encoding and the fetch FSM state type.
package pipeline_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } fetch_state_e;

endpackage : pipeline_pkg

// File: rtl/fetch_stage_if.sv
// Instruction-ROM bus between the fetch stage (master, drives the address)
// and a combinational ROM (slave, returns the word in the same cycle).
interface fetch_stage_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
);

    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_instr;

    modport master (output rom_addr, input  rom_instr);
    modport slave  (input  rom_addr, output rom_instr);

endinterface : fetch_stage_if

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: flush loads a NOP bubble and wins over enable;
// otherwise enable captures the fetched word and its PC+4.
module if_id_register
    import pipeline_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_plus4_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_plus4_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_plus4_q;
    logic               valid_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            instr_q    <= INSTR_W'(NOP_INSTR);
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (enable_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule : if_id_register

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, remembers a branch redirect that
// arrives during a stall, feeds the IF/ID register and counts fetches.
module fetch_stage #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_pc,
    input  logic               enable_ifid,
    input  logic               flush_ifid,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    fetch_stage_if.master      rom,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ifid_instruction,
    output logic [PC_W-1:0]    ifid_pc_plus4,
    output logic               ifid_valid,
    output logic               redirect_pending,
    output logic [CNT_W-1:0]   fetch_count
);

    import pipeline_pkg::*;

    fetch_state_e      state_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   pending_target_q;
    logic [CNT_W-1:0]  fetch_count_q;
    logic              ifid_load;

    // Natural width truncation gives the modulo-2^PC_W wrap (252 -> 0).
    assign pc_plus4 = pc_q + PC_W'(PC_INC);

    // NOTE: every variable written here gets a default first, so no latch
    // can be inferred on any path through the priority chain.
    always_comb begin
        pc_d = pc_plus4;
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (state_q == PENDING) begin
            pc_d = pending_target_q;
        end
    end

    // A fresh branch outranks a remembered one, so the newest target always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q             <= '0;
            pending_target_q <= '0;
            state_q          <= RUN;
        end else if (enable_pc) begin
            pc_q    <= pc_d;
            state_q <= RUN;
        end else if (branch_taken) begin
            pending_target_q <= branch_target;
            state_q          <= PENDING;
        end
    end

    assign ifid_load = enable_ifid && !flush_ifid;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else if (ifid_load && (fetch_count_q != '1)) begin
            fetch_count_q <= fetch_count_q + 1'b1;
        end
    end

    if_id_register #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .enable_i   (enable_ifid),
        .flush_i    (flush_ifid),
        .instr_i    (rom.rom_instr),
        .pc_plus4_i (pc_plus4),
        .instr_o    (ifid_instruction),
        .pc_plus4_o (ifid_pc_plus4),
        .valid_o    (ifid_valid)
    );

    assign rom.rom_addr     = pc_q;
    assign pc               = pc_q;
    assign redirect_pending = (state_q == PENDING);
    assign fetch_count      = fetch_count_q;

endmodule : fetch_stage
